// File: rtl/izhikevich_state_update.sv
// Euler state-update stage of the Izhikevich core: integrates dv/dw into v/w with
// saturation, then applies spike detection and the (c, d) after-spike reset.
module izhikevich_state_update #(
    parameter int unsigned         N      = 18,
    parameter int unsigned         Q      = 8,
    parameter logic signed [N-1:0] V_TH   = N'(30 << Q),
    parameter logic signed [N-1:0] V_INIT = N'(-(65 << Q)),
    parameter logic signed [N-1:0] W_INIT = N'(-(13 << Q))
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic signed [N-1:0] dv,
    input  logic signed [N-1:0] dw,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    output logic signed [N-1:0] v,
    output logic signed [N-1:0] w,
    output logic                out_valid,
    output logic                spike,
    output logic                sat,
    output logic [15:0]         spike_count
);

    localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [15:0]         CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        COMMIT
    } state_t;

    state_t              state;
    logic signed [N-1:0] dv_q, dw_q, c_q, d_q;
    logic signed [N-1:0] v_sum, w_sum;
    logic                v_ovf, w_ovf;

    // Sign-extended add; the two top bits disagree exactly when the N-bit result overflows.
    function automatic logic signed [N:0] wide_add(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        return {a[N-1], a} + {b[N-1], b};
    endfunction

    function automatic logic add_ovf(input logic signed [N-1:0] a,
                                     input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = wide_add(a, b);
        return s[N] ^ s[N-1];
    endfunction

    function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = wide_add(a, b);
        if (s[N] ^ s[N-1]) return s[N] ? S_MIN : S_MAX;
        return s[N-1:0];
    endfunction

    assign upd_ready = (state == IDLE);

    // Three-cycle step: capture, add, commit with spike/reset handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            v           <= V_INIT;
            w           <= W_INIT;
            out_valid   <= 1'b0;
            spike       <= 1'b0;
            sat         <= 1'b0;
            spike_count <= '0;
            dv_q        <= '0;
            dw_q        <= '0;
            c_q         <= '0;
            d_q         <= '0;
            v_sum       <= '0;
            w_sum       <= '0;
            v_ovf       <= 1'b0;
            w_ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            spike     <= 1'b0;
            sat       <= 1'b0;
            case (state)
                IDLE: begin
                    if (upd_valid) begin
                        dv_q  <= dv;
                        dw_q  <= dw;
                        c_q   <= c;
                        d_q   <= d;
                        state <= ADD;
                    end
                end
                ADD: begin
                    v_sum <= sat_add(v, dv_q);
                    w_sum <= sat_add(w, dw_q);
                    v_ovf <= add_ovf(v, dv_q);
                    w_ovf <= add_ovf(w, dw_q);
                    state <= COMMIT;
                end
                COMMIT: begin
                    out_valid <= 1'b1;
                    if (v_sum >= V_TH) begin
                        v     <= c_q;
                        w     <= sat_add(w_sum, d_q);
                        spike <= 1'b1;
                        sat   <= v_ovf | w_ovf | add_ovf(w_sum, d_q);
                        if (spike_count != CNT_MAX) spike_count <= spike_count + 16'd1;
                    end else begin
                        v   <= v_sum;
                        w   <= w_sum;
                        sat <= v_ovf | w_ovf;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
